// File: rtl/jk_excitation_driver_pkg.sv
// Shared types and JK code points for the JK flop-bank excitation driver.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } drv_state_e;

    // {J,K} pairs as presented to one flop
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target handshake and transaction status between a requester and the JK excitation driver.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 8
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output tgt_valid, tgt_data,
        input  tgt_ready, busy, done, err
    );

    modport slave (
        input  tgt_valid, tgt_data,
        output tgt_ready, busy, done, err
    );
endinterface

// File: rtl/jk_excitation_driver_enc.sv
// Single-bit JK excitation encoder: picks {J,K} that moves q_now to q_next.
// Build option JK_TOGGLE_EN encodes every change as a toggle instead of set/reset.
module jk_excite_enc
    import jk_drv_pkg::*;
(
    input  logic       q_now,
    input  logic       q_next,
    output logic [1:0] jk
);

`ifdef JK_TOGGLE_EN
    always_comb begin
        jk = (q_now != q_next) ? JK_TGL : JK_HOLD;
    end
`else
    always_comb begin
        jk = JK_HOLD;
        if (!q_now && q_next)
            jk = JK_SET;
        else if (q_now && !q_next)
            jk = JK_RST;
    end
`endif

endmodule

// File: rtl/jk_excitation_driver.sv
// Controller for a bank of JK flops: encodes a target word into a one-cycle J/K
// pulse, then watches Q until it matches or the settle budget runs out (JK_TOGGLE_EN selects encoding).
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jk_excitation_driver_if.slave tgt,
    input  logic [WIDTH-1:0]      q_fb,
    output logic [WIDTH-1:0]      j_out,
    output logic [WIDTH-1:0]      k_out
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(SETTLE_CYC);

    drv_state_e       state_reg, state_next;
    logic [WIDTH-1:0] tgt_reg, tgt_next;
    logic [WIDTH-1:0] j_reg, j_next;
    logic [WIDTH-1:0] k_reg, k_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [WIDTH-1:0] j_enc, k_enc;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
            logic [1:0] jk_bit;
            jk_excite_enc u_enc (
                .q_now  (q_fb[gi]),
                .q_next (tgt.tgt_data[gi]),
                .jk     (jk_bit)
            );
            assign j_enc[gi] = jk_bit[1];
            assign k_enc[gi] = jk_bit[0];
        end
    endgenerate

    assign cnt_inc = (cnt_reg == CNT_LIM) ? cnt_reg : cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        j_next     = '0;
        k_next     = '0;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        unique case (state_reg)
            IDLE: begin
                if (tgt.tgt_valid) begin
                    tgt_next   = tgt.tgt_data;
                    j_next     = j_enc;
                    k_next     = k_enc;
                    err_next   = 1'b0;
                    state_next = DRIVE;
                end
            end
            // J/K are only ever non-zero in this single cycle; a second toggle would undo the first
            DRIVE: begin
                cnt_next   = '0;
                state_next = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CNT_LIM) begin
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            tgt_reg   <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign j_out         = j_reg;
    assign k_out         = k_reg;
    assign tgt.tgt_ready = (state_reg == IDLE);
    assign tgt.busy      = (state_reg != IDLE);
    assign tgt.done      = done_reg;
    assign tgt.err       = err_reg;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: closes j_out/k_out through a behavioural JK flop bank and checks handshake, encoding and timing.
module tb_jk_excitation_driver;

    localparam int WIDTH      = 8;
    localparam int SETTLE_CYC = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;

    logic [WIDTH-1:0] bank_q;
    logic             bank_load;
    logic [WIDTH-1:0] bank_load_val;
    logic             stuck_en;
    logic [WIDTH-1:0] stuck_val;

    int checks;
    int errors;

    jk_excitation_driver_if #(.WIDTH(WIDTH)) tgt_if ();

    jk_excitation_driver #(
        .WIDTH      (WIDTH),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tgt   (tgt_if.slave),
        .q_fb  (q_fb),
        .j_out (j_out),
        .k_out (k_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK flop bank with a preload port
    always @(posedge clk) begin
        if (bank_load)
            bank_q <= bank_load_val;
        else
            for (int b = 0; b < WIDTH; b++)
                case ({j_out[b], k_out[b]})
                    2'b10:   bank_q[b] <= 1'b1;
                    2'b01:   bank_q[b] <= 1'b0;
                    2'b11:   bank_q[b] <= ~bank_q[b];
                    default: bank_q[b] <= bank_q[b];
                endcase
    end

    assign q_fb = stuck_en ? stuck_val : bank_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Called at a negedge with the driver idle; returns at a negedge
    task automatic load_q(input logic [WIDTH-1:0] v);
        bank_load     = 1'b1;
        bank_load_val = v;
        @(negedge clk);
        bank_load = 1'b0;
    endtask

    // One transaction: checks the drive vector, done timing and err; returns at the negedge after done
    task automatic run_txn(input string name, input logic [WIDTH-1:0] tgt,
                           input logic [WIDTH-1:0] exp_j, input logic [WIDTH-1:0] exp_k,
                           input int done_cyc, input logic exp_err);
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = tgt;
        @(posedge clk);
        for (int n = 1; n <= done_cyc; n++) begin
            @(negedge clk);
            if (n == 1) begin
                tgt_if.tgt_valid = 1'b0;
                check({name, " drive j"}, j_out, exp_j);
                check({name, " drive k"}, k_out, exp_k);
                check({name, " drive busy"}, tgt_if.busy, 1'b1);
                check({name, " drive ready"}, tgt_if.tgt_ready, 1'b0);
            end
            if (n == 2)
                check({name, " jk cleared"}, {j_out, k_out}, '0);
            check($sformatf("%s done@%0d", name, n), tgt_if.done, (n == done_cyc));
        end
        check({name, " err"}, tgt_if.err, exp_err);
        check({name, " ready at done"}, tgt_if.tgt_ready, 1'b1);
        @(negedge clk);
        check({name, " done pulse ends"}, tgt_if.done, 1'b0);
    endtask

    logic [WIDTH-1:0] exp_j3, exp_k3, exp_j6, exp_k6;

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        tgt_if.tgt_valid = 1'b0;
        tgt_if.tgt_data  = '0;
        bank_load        = 1'b0;
        bank_load_val    = '0;
        stuck_en         = 1'b0;
        stuck_val        = '0;
`ifdef JK_TOGGLE_EN
        exp_j3 = 8'hF0; exp_k3 = 8'hF0;
        exp_j6 = 8'hFF; exp_k6 = 8'hFF;
`else
        exp_j3 = 8'h00; exp_k3 = 8'hF0;
        exp_j6 = 8'h5A; exp_k6 = 8'hA5;
`endif

        @(negedge clk);
        check("reset jk", {j_out, k_out}, '0);
        check("reset ready", tgt_if.tgt_ready, 1'b1);
        check("reset busy/done/err", {tgt_if.busy, tgt_if.done, tgt_if.err}, 3'b000);
        rst_n = 1'b1;
        load_q(8'h00);

        // 1: asynchronous reset while driving
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = 8'hA5;
        @(negedge clk);
        tgt_if.tgt_valid = 1'b0;
        check("t1 drive j", j_out, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("t1 async jk", {j_out, k_out}, '0);
        check("t1 async ready", tgt_if.tgt_ready, 1'b1);
        check("t1 async busy/done", {tgt_if.busy, tgt_if.done}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("t1 no done after reset", tgt_if.done, 1'b0);
        end
        check("t1 bank untouched", q_fb, 8'h00);

        // 2: set/reset path
        load_q(8'h00);
        run_txn("t2", 8'hA5, 8'hA5, 8'h00, 3, 1'b0);
        check("t2 q", q_fb, 8'hA5);

        // 3: encoding depends on build
        load_q(8'hFF);
        run_txn("t3", 8'h0F, exp_j3, exp_k3, 3, 1'b0);
        check("t3 q", q_fb, 8'h0F);

        // 4: no-op target
        load_q(8'h3C);
        run_txn("t4", 8'h3C, 8'h00, 8'h00, 3, 1'b0);
        check("t4 q", q_fb, 8'h3C);

        // 5: stuck bank times out, next accept clears err
        stuck_en  = 1'b1;
        stuck_val = 8'h00;
        run_txn("t5", 8'h01, 8'h01, 8'h00, 6, 1'b1);
        check("t5 err held", tgt_if.err, 1'b1);
        stuck_en = 1'b0;
        load_q(8'h00);
        check("t5 err held idle", tgt_if.err, 1'b1);
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = 8'h00;
        @(negedge clk);
        tgt_if.tgt_valid = 1'b0;
        check("t5 err cleared on accept", tgt_if.err, 1'b0);
        repeat (4) @(negedge clk);

        // 6: back-to-back with tgt_valid held
        load_q(8'h00);
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = 8'hA5;
        @(posedge clk);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) begin
                tgt_if.tgt_data = 8'h5A;
                check("t6 first j", j_out, 8'hA5);
            end
            if (n == 3)
                check("t6 ready in done cycle", tgt_if.tgt_ready, 1'b1);
            if (n == 4) begin
                tgt_if.tgt_valid = 1'b0;
                check("t6 second j", j_out, exp_j6);
                check("t6 second k", k_out, exp_k6);
            end
            check($sformatf("t6 done@%0d", n), tgt_if.done, (n == 3 || n == 6));
        end
        check("t6 q", q_fb, 8'h5A);
        check("t6 err", tgt_if.err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
